// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUCtrl codes, ALUOp encodings and the
// sequencer FSM state type. The ALU decodes the same ALUCtrl constants.
package alu_pkg;

    // 4-bit ALUCtrl codes driven to the ALU
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_XOR  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_ADD  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0100;
    localparam logic [3:0] ALU_MUL  = 4'b0101;
    localparam logic [3:0] ALU_ADDI = 4'b0110;
    localparam logic [3:0] ALU_SRAI = 4'b0111;
    localparam logic [3:0] ALU_LDST = 4'b1000;
    localparam logic [3:0] ALU_BEQ  = 4'b1001;

    // ALUOp field from the main decoder
    localparam logic [1:0] OP_LDST  = 2'b00;
    localparam logic [1:0] OP_BR    = 2'b01;
    localparam logic [1:0] OP_RTYPE = 2'b10;
    localparam logic [1:0] OP_ITYPE = 2'b11;

    // funct7 values that select between base, alternate and M-extension ops
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier datapath: operand latch, accumulator and
// iteration counter. Sequencing (start/abort/done) is owned by the caller.
module mul_iter #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_load,
    input  logic        i_step,
    input  logic [31:0] i_mcand,
    input  logic [31:0] i_mplier,
    output logic [31:0] o_acc_nxt,
    output logic        o_last
);

    localparam int N = 32 / BITS_PER_CYCLE;

    logic [31:0] r_acc;
    logic [31:0] r_mcand;
    logic [31:0] r_mplier;
    logic [5:0]  r_cnt;
    logic [31:0] w_digit;
    logic [31:0] w_pp;

    // Low multiplier digit times the shifted multiplicand; overflow is dropped
    assign w_digit   = {{(32-BITS_PER_CYCLE){1'b0}}, r_mplier[BITS_PER_CYCLE-1:0]};
    assign w_pp      = r_mcand * w_digit;
    assign o_acc_nxt = r_acc + w_pp;
    assign o_last    = (r_cnt == 6'(N-1));

    // Latch operands on load, retire BITS_PER_CYCLE multiplier bits per step
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else if (i_load) begin
            r_acc    <= '0;
            r_mcand  <= i_mcand;
            r_mplier <= i_mplier;
            r_cnt    <= '0;
        end else if (i_step) begin
            r_acc    <= o_acc_nxt;
            r_mcand  <= r_mcand << BITS_PER_CYCLE;
            r_mplier <= r_mplier >> BITS_PER_CYCLE;
            r_cnt    <= r_cnt + 6'd1;
        end
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// EX-stage ALU control: decodes ALUOp/funct7/funct3 into ALUCtrl and runs
// MUL on an iterative multiplier, stalling the pipeline until it finishes.
module alu_ctrl_seq
    import alu_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        valid_i,
    input  logic        flush_i,
    input  logic [1:0]  ALUOp_i,
    input  logic [6:0]  funct7_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] data1_i,
    input  logic [31:0] data2_i,
    output logic [3:0]  ALUCtrl_o,
    output logic        mul_sel_o,
    output logic [31:0] mul_result_o,
    output logic        stall_o
);

    state_t      r_state;
    logic        r_mul_sel;
    logic [31:0] r_mul_result;
    logic [3:0]  w_alu_ctrl;
    logic        w_is_mul;
    logic        w_start;
    logic        w_step;
    logic        w_last;
    logic [31:0] w_acc_nxt;

    // Decode; anything not explicitly listed falls back to ADD
    always_comb begin
        w_alu_ctrl = ALU_ADD;
        case (ALUOp_i)
            OP_LDST: w_alu_ctrl = ALU_LDST;
            OP_BR:   w_alu_ctrl = ALU_BEQ;
            OP_RTYPE: begin
                if (funct7_i == F7_BASE) begin
                    case (funct3_i)
                        3'b111:  w_alu_ctrl = ALU_AND;
                        3'b100:  w_alu_ctrl = ALU_XOR;
                        3'b001:  w_alu_ctrl = ALU_SLL;
                        default: w_alu_ctrl = ALU_ADD;
                    endcase
                end else if (funct7_i == F7_ALT && funct3_i == 3'b000) begin
                    w_alu_ctrl = ALU_SUB;
                end else if (funct7_i == F7_MUL && funct3_i == 3'b000) begin
                    w_alu_ctrl = ALU_MUL;
                end
            end
            default: begin
                if (funct3_i == 3'b000)
                    w_alu_ctrl = ALU_ADDI;
                else if (funct3_i == 3'b101 && funct7_i == F7_ALT)
                    w_alu_ctrl = ALU_SRAI;
            end
        endcase
    end

    assign w_is_mul  = (w_alu_ctrl == ALU_MUL);
    // Flush wins over a new start and aborts an in-flight multiply
    assign w_start   = valid_i & w_is_mul & ~flush_i & (r_state == ST_IDLE);
    assign w_step    = ~flush_i & (r_state == ST_BUSY);

    assign ALUCtrl_o    = w_alu_ctrl;
    // Stall is raised in the start cycle itself so ID/EX holds the MUL;
    // gated by reset so it reads 0 while reset is asserted
    assign stall_o      = rst_n_i & (w_start | w_step);
    assign mul_sel_o    = r_mul_sel;
    assign mul_result_o = r_mul_result;

    mul_iter #(
        .BITS_PER_CYCLE(BITS_PER_CYCLE)
    ) u_mul_iter (
        .i_clk     (clk_i),
        .i_rst_n   (rst_n_i),
        .i_load    (w_start),
        .i_step    (w_step),
        .i_mcand   (data1_i),
        .i_mplier  (data2_i),
        .o_acc_nxt (w_acc_nxt),
        .o_last    (w_last)
    );

    // Sequencer: IDLE -> BUSY for N cycles -> one DONE cycle presenting the result
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state      <= ST_IDLE;
            r_mul_sel    <= 1'b0;
            r_mul_result <= '0;
        end else begin
            r_mul_sel <= 1'b0;
            if (flush_i) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: if (w_start) r_state <= ST_BUSY;
                    ST_BUSY: begin
                        if (w_last) begin
                            r_state      <= ST_DONE;
                            r_mul_sel    <= 1'b1;
                            r_mul_result <= w_acc_nxt;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Bench for alu_ctrl_seq: one instance with 1 bit/cycle, one with 4 bits/cycle.
// The driver pushes expected responses; a negedge monitor pops and compares.
module tb_alu_ctrl_seq;

    logic        clk;
    logic        rst_n;
    logic        valid1, valid4;
    logic        flush;
    logic [1:0]  aluop;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] d1, d2;

    logic [3:0]  ctrl1, ctrl4;
    logic        sel1, sel4, stall1, stall4;
    logic [31:0] res1, res4;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          inst;
        logic [31:0] res;
        int          len;
    } exp_t;

    typedef struct packed {
        logic        v;
        logic [1:0]  op;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [3:0]  exp;
    } dvec_t;

    exp_t        qm[$];
    logic [3:0]  qc[$];
    logic        chk_ctrl;

    logic        st  [2];
    logic        sel [2];
    logic [31:0] res [2];
    int          run [2];

    assign st[0]  = stall1;
    assign st[1]  = stall4;
    assign sel[0] = sel1;
    assign sel[1] = sel4;
    assign res[0] = res1;
    assign res[1] = res4;

    alu_ctrl_seq #(.BITS_PER_CYCLE(1)) u_dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid1), .flush_i(flush),
        .ALUOp_i(aluop), .funct7_i(f7), .funct3_i(f3), .data1_i(d1), .data2_i(d2),
        .ALUCtrl_o(ctrl1), .mul_sel_o(sel1), .mul_result_o(res1), .stall_o(stall1)
    );

    alu_ctrl_seq #(.BITS_PER_CYCLE(4)) u_dut4 (
        .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid4), .flush_i(flush),
        .ALUOp_i(aluop), .funct7_i(f7), .funct3_i(f3), .data1_i(d1), .data2_i(d2),
        .ALUCtrl_o(ctrl4), .mul_sel_o(sel4), .mul_result_o(res4), .stall_o(stall4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Monitor: decode checks on strobe, MUL results and stall length on mul_sel
    always @(negedge clk) begin
        exp_t e;
        if (chk_ctrl) begin
            chk("aluctrl", {28'd0, ctrl1}, {28'd0, qc.pop_front()});
            chk("decode_nostall", {31'd0, stall1}, 32'd0);
        end
        for (int k = 0; k < 2; k++) begin
            if (sel[k]) begin
                if (qm.size() == 0) begin
                    chk("unexpected_mul_sel", 32'd1, 32'd0);
                end else begin
                    e = qm.pop_front();
                    chk("mul_inst", k, e.inst);
                    chk("mul_result", res[k], e.res);
                    chk("stall_len", run[k], e.len);
                end
                run[k] = 0;
            end else if (st[k]) begin
                run[k] = run[k] + 1;
            end else begin
                run[k] = 0;
            end
        end
    end

    task automatic drive_mul(input int inst, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        aluop = 2'b10; f7 = 7'b0000001; f3 = 3'b000; d1 = a; d2 = b;
        valid1 = (inst == 0);
        valid4 = (inst == 1);
    endtask

    // Issue a MUL, optionally scramble operands mid-run, wait for the DONE cycle
    task automatic do_mul(input int inst, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input int elen, input bit scramble);
        exp_t e;
        bit   done;
        drive_mul(inst, a, b);
        e.inst = inst; e.res = er; e.len = elen;
        qm.push_back(e);
        done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (scramble && i == 5) begin
                d1 = $urandom; d2 = $urandom;
            end
            if (!((inst == 0) ? stall1 : stall4)) done = 1;
        end
        if (!done) chk("mul_timeout", 32'd1, 32'd0);
    endtask

    task automatic go_idle();
        @(posedge clk); #1;
        valid1 = 0; valid4 = 0;
        aluop = 2'b00; f7 = '0; f3 = '0;
    endtask

    dvec_t dv [12] = '{
        {1'b1, 2'b10, 7'b0000000, 3'b111, 4'b0000},
        {1'b1, 2'b10, 7'b0000000, 3'b100, 4'b0001},
        {1'b1, 2'b10, 7'b0000000, 3'b001, 4'b0010},
        {1'b1, 2'b10, 7'b0000000, 3'b000, 4'b0011},
        {1'b1, 2'b10, 7'b0100000, 3'b000, 4'b0100},
        {1'b1, 2'b11, 7'b0000000, 3'b000, 4'b0110},
        {1'b1, 2'b11, 7'b0100000, 3'b101, 4'b0111},
        {1'b1, 2'b11, 7'b0000000, 3'b101, 4'b0011},
        {1'b1, 2'b00, 7'b0000000, 3'b010, 4'b1000},
        {1'b1, 2'b01, 7'b0000000, 3'b000, 4'b1001},
        {1'b1, 2'b10, 7'b0000001, 3'b001, 4'b0011},
        {1'b0, 2'b10, 7'b0000001, 3'b000, 4'b0101}
    };

    initial begin
        run[0] = 0; run[1] = 0;
        chk_ctrl = 0;
        rst_n = 0; flush = 0;
        valid1 = 1; valid4 = 0;
        aluop = 2'b10; f7 = 7'b0000001; f3 = 3'b000; d1 = 32'd3; d2 = 32'd4;

        // Reset state, with a valid MUL sitting on the inputs
        #12;
        chk("rst_stall", {31'd0, stall1}, 32'd0);
        chk("rst_mul_sel", {31'd0, sel1}, 32'd0);
        chk("rst_result", res1, 32'd0);
        valid1 = 0;
        @(posedge clk); #1;
        rst_n = 1;

        // Decode table, one vector per cycle
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            valid1 = dv[i].v; aluop = dv[i].op; f7 = dv[i].f7; f3 = dv[i].f3;
            qc.push_back(dv[i].exp);
            chk_ctrl = 1;
        end
        @(posedge clk); #1;
        chk_ctrl = 0;
        valid1 = 0;

        // 7 * -3, operands scrambled while busy
        do_mul(0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 1'b1);
        do_mul(0, 32'h8000_0000, 32'd2, 32'd0, 33, 1'b0);
        go_idle();
        do_mul(1, 32'h8000_0000, 32'd2, 32'd0, 9, 1'b0);
        go_idle();
        do_mul(1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 9, 1'b1);
        go_idle();

        // Flush at BUSY cycle 10: stall drops immediately, no result
        drive_mul(0, 32'd7, 32'd3);
        repeat (10) @(posedge clk);
        #1 flush = 1;
        #1 chk("flush_stall", {31'd0, stall1}, 32'd0);
        @(posedge clk); #1;
        flush = 0; valid1 = 0;
        #1 chk("post_flush_idle", {31'd0, stall1}, 32'd0);
        repeat (3) @(posedge clk);
        do_mul(0, 32'd12345, 32'd3, 32'd37035, 33, 1'b0);

        // Back-to-back MULs
        do_mul(0, 32'd5, 32'd6, 32'd30, 33, 1'b0);
        do_mul(0, 32'd9, 32'd9, 32'd81, 33, 1'b0);
        go_idle();

        // Async reset mid-BUSY
        drive_mul(0, 32'd11, 32'd13);
        repeat (5) @(posedge clk);
        #1 rst_n = 0;
        #1;
        chk("midrst_stall", {31'd0, stall1}, 32'd0);
        chk("midrst_mul_sel", {31'd0, sel1}, 32'd0);
        chk("midrst_result", res1, 32'd0);
        @(posedge clk); #1;
        valid1 = 0;
        @(posedge clk); #1;
        rst_n = 1;
        do_mul(0, 32'd100, 32'd200, 32'd20000, 33, 1'b0);
        go_idle();

        repeat (5) @(posedge clk);
        chk("pending_expectations", qm.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
